max3421e_spi_responder: RTL and testbench
=========================================

Name: max3421e_spi_responder

Overview:
Synthesizable SPI slave that models the MAX3421E register interface, i.e. the device end of the bus our usb_controller drives as master. It holds a 32 x 8 register file, answers SPI command/data transfers, returns the HIRQ status byte during every command byte, and drives an active-low interrupt pin. It is used for on-FPGA loopback bring-up of usb_controller without the physical chip, and as a bench model.

Parameters:
STATUS_REG, 25, register index whose value is shifted out during each command byte (HIRQ).
IRQ_EN_REG, 26, register index ANDed with STATUS_REG to form the interrupt (HIEN).
SYNC_STAGES, 2, synchronizer depth on sclk_in, mosi_in and n_ss_in.

Ports:
clk_in  input  1  system clock; must be at least 4x the SCLK frequency.
n_rst_in  input  1  asynchronous, active-low reset.
sclk_in  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
mosi_in  input  1  SPI data from master, MSB first.
n_ss_in  input  1  active-low slave select.
miso_out  output  1  SPI data to master, MSB first.
n_int_out  output  1  active-low interrupt.
host_wr_in  input  1  local write strobe into the register file (used to set HIRQ bits etc.).
host_addr_in  input  5  local write address.
host_data_in  input  8  local write data.
wr_valid_out  output  1  1-cycle pulse when an SPI write commits.
wr_addr_out  output  5  register index of the committed SPI write.
wr_data_out  output  8  data of the committed SPI write.

Behaviour:
- Reset (n_rst_in low, async): all registers 0; FSM IDLE; miso_out 0; n_int_out 1; wr_valid_out 0; wr_addr_out 0; wr_data_out 0.
- Inputs pass through SYNC_STAGES flops. Rise/fall of sclk is detected on the synchronized signal. All logic runs on clk_in.
- Command byte: bits[7:3] reg index, bit1 DIR (1 = write, 0 = read), bits 2 and 0 ignored.
- FSM IDLE -> CMD on the synchronized n_ss falling edge. In the same cycle, load the shift register with regs[STATUS_REG] and drive its bit7 on miso_out.
- In CMD and DATA: sample mosi on each sclk rise, with bit counter 0..7. Shift the next miso bit on each sclk fall.
- CMD -> DATA on the 8th rise: latch addr and DIR. If the access is a read, preload the shift register with regs[addr]; its bit7 is presented on the following sclk fall.
- DATA, write: on each 8th rise, regs[addr] <= received byte; wr_valid_out pulses 1 cycle the next cycle with wr_addr_out/wr_data_out. miso_out shifts 0s during write data.
- DATA, read: each completed byte reloads from regs[addr]. The address does not auto-increment; bursts repeat the same register (FIFO semantics).
- n_ss rise in any state: abort to IDLE, discard any partial byte, miso_out <= 0. A partial data byte never commits.
- Host write and SPI commit to the same address in the same cycle: the SPI write wins. Host writes to different addresses proceed concurrently.
- n_int_out = ~|(regs[STATUS_REG] & regs[IRQ_EN_REG]), registered with 1-cycle latency.
- sclk edges while IDLE are ignored. Bit counter width is 3 bits and wraps 7 -> 0 at each byte.

Optional Feature:
MAX3421E_W1C_IRQ_EN.
- Defined: an SPI write to STATUS_REG clears each bit written as 1 (regs <= regs & ~data). wr_data_out still reports the raw byte written. In a same-cycle collision between a host write to STATUS_REG and this clear, the result is (host_data_in & ~spi_data).
- Undefined: STATUS_REG is written like any other register.

Test Plan:
- Reset: hold n_rst_in=0, toggle sclk_in and n_ss_in -> miso_out=0, n_int_out=1, wr_valid_out=0, and all registers read 0 afterwards.
- SPI write: command 0x8A (reg 17, write) + data 0x5C -> one wr_valid_out pulse with addr=17 and data=0x5C. A later read 0x88 + dummy byte returns 0x5C on MISO.
- Status byte: host writes reg 25 = 0xA5, then the master sends any command -> MISO bytes during the command are 0xA5.
- Read burst: reg 8 = 0x3C, command 0x40 + three dummy bytes -> MISO returns 0x00 (status), 0x3C, 0x3C, 0x3C.
- Interrupt and abort: regs 25 = 0x04 and 26 = 0x04 -> n_int_out=0. Raise n_ss after 4 data bits of a write to reg 26 -> no wr_valid_out pulse and reg 26 unchanged.
- With MAX3421E_W1C_IRQ_EN and reg 25 = 0x0F: write 0xCA with data 0x05 -> reg 25 = 0x0A. Without the macro -> reg 25 = 0x05.

Source files
------------

// File: rtl/max3421e_spi_responder.sv
// ----------------------------------------------------------------------------
// max3421e_spi_responder
//
// SPI mode-0 slave that behaves like the MAX3421E register interface. It is
// the device end of the bus driven by usb_controller, used for on-FPGA
// loopback bring-up and as a bench model.
//
//   - 32 x 8 register file, written by the SPI master or the local host port.
//   - During every command byte the HIRQ status register is shifted out.
//   - Command byte: [7:3] register index, [1] DIR (1 = write), [2],[0] unused.
//   - Reads do not auto-increment: a burst keeps returning the same register.
//   - n_int_out = ~|(HIRQ & HIEN), registered.
//
// Parameters:
//   STATUS_REG   register shifted out during each command byte (HIRQ)
//   IRQ_EN_REG   register ANDed with STATUS_REG for the interrupt (HIEN)
//   SYNC_STAGES  synchronizer depth on sclk_in / mosi_in / n_ss_in (>= 2)
//
// Ports:
//   clk_in        system clock, >= 4x SCLK
//   n_rst_in      asynchronous active-low reset
//   sclk_in       SPI clock (CPOL=0, CPHA=0)
//   mosi_in       SPI data in, MSB first
//   n_ss_in       active-low slave select
//   miso_out      SPI data out, MSB first
//   n_int_out     active-low interrupt
//   host_wr_in    local register write strobe
//   host_addr_in  local write address
//   host_data_in  local write data
//   wr_valid_out  1-cycle pulse after an SPI write commits
//   wr_addr_out   register index of the committed SPI write
//   wr_data_out   data byte of the committed SPI write (raw, as received)
//
// Build option:
//   MAX3421E_W1C_IRQ_EN  when defined, SPI writes to STATUS_REG clear the bits
//                        written as 1 instead of overwriting the register.
// ----------------------------------------------------------------------------
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | slave not selected, SCLK ignored
// ST_CMD  | shifting in the command byte, HIRQ shifted out
// ST_DATA | data bytes: write commits or read returns regs[addr] per byte
//
module max3421e_spi_responder #(
  parameter logic [4:0] STATUS_REG  = 5'd25,
  parameter logic [4:0] IRQ_EN_REG  = 5'd26,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       n_rst_in,
  input  logic       sclk_in,
  input  logic       mosi_in,
  input  logic       n_ss_in,
  output logic       miso_out,
  output logic       n_int_out,
  input  logic       host_wr_in,
  input  logic [4:0] host_addr_in,
  input  logic [7:0] host_data_in,
  output logic       wr_valid_out,
  output logic [4:0] wr_addr_out,
  output logic [7:0] wr_data_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic                   r_sclk_d;
  logic                   r_ss_d;

  logic       w_sclk;
  logic       w_mosi;
  logic       w_ss;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_ss_rise;
  logic       w_ss_fall;

  logic [7:0] r_regs [32];
  logic [7:0] r_shift_tx;
  logic [7:0] r_shift_rx;
  logic [2:0] r_bit_cnt;
  logic [4:0] r_addr;
  logic       r_dir;
  logic       r_miso;
  logic       r_n_int;
  logic       r_wr_valid;
  logic [4:0] r_wr_addr;
  logic [7:0] r_wr_data;

  logic [7:0] w_rx_byte;
  logic       w_byte_done;
  logic       w_spi_commit;

  // --------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // --------------------------------------------------------------------------
  // Slave select resets high so that reset release does not look like a
  // select edge when the master is idle.
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], n_ss_in};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_rise   = w_ss & ~r_ss_d;
  assign w_ss_fall   = ~w_ss & r_ss_d;

  // mosi travels through the same number of stages as sclk, so the value
  // seen alongside the detected rise is the one the master set up.
  assign w_rx_byte   = {r_shift_rx[6:0], w_mosi};
  assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);

  // Deselect wins over a coincident final edge: an aborted transfer never
  // commits anything.
  assign w_spi_commit = (r_state == ST_DATA) && w_byte_done && r_dir && !w_ss_rise;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        if (w_ss_rise) begin
          w_state_nxt = ST_IDLE;
        end else if (w_byte_done) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_ss_rise) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift datapath
  // --------------------------------------------------------------------------
  // A fall with r_bit_cnt == 0 directly follows a byte boundary (or is the
  // first fall after a fresh load). The freshly loaded byte's MSB is then
  // presented as-is; every other fall advances the shift register by one.
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      r_shift_tx <= 8'h00;
      r_shift_rx <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_addr     <= 5'd0;
      r_dir      <= 1'b0;
      r_miso     <= 1'b0;
    end else if (w_ss_rise) begin
      r_bit_cnt  <= 3'd0;
      r_shift_rx <= 8'h00;
      r_miso     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_shift_tx <= r_regs[STATUS_REG];
            r_miso     <= r_regs[STATUS_REG][7];
            r_bit_cnt  <= 3'd0;
          end
        end
        ST_CMD, ST_DATA: begin
          if (w_sclk_rise) begin
            r_shift_rx <= w_rx_byte;
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (r_state == ST_CMD) begin
                r_addr     <= w_rx_byte[7:3];
                r_dir      <= w_rx_byte[1];
                r_shift_tx <= w_rx_byte[1] ? 8'h00 : r_regs[w_rx_byte[7:3]];
              end else if (!r_dir) begin
                r_shift_tx <= r_regs[r_addr];
              end
            end
          end else if (w_sclk_fall) begin
            if (r_bit_cnt == 3'd0) begin
              r_miso <= r_shift_tx[7];
            end else begin
              r_shift_tx <= {r_shift_tx[6:0], 1'b0};
              r_miso     <= r_shift_tx[6];
            end
          end
        end
        default: begin
          r_bit_cnt <= 3'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register file: an SPI commit has priority over a host write to the same
  // address; host writes elsewhere proceed in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (w_spi_commit && (r_addr == i[4:0])) begin
`ifdef MAX3421E_W1C_IRQ_EN
          if (i[4:0] == STATUS_REG) begin
            // Clear-on-write-1; a colliding host write supplies the base value.
            if (host_wr_in && (host_addr_in == STATUS_REG)) begin
              r_regs[i] <= host_data_in & ~w_rx_byte;
            end else begin
              r_regs[i] <= r_regs[i] & ~w_rx_byte;
            end
          end else begin
            r_regs[i] <= w_rx_byte;
          end
`else
          r_regs[i] <= w_rx_byte;
`endif
        end else if (host_wr_in && (host_addr_in == i[4:0])) begin
          r_regs[i] <= host_data_in;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Commit report and interrupt
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 5'd0;
      r_wr_data  <= 8'h00;
      r_n_int    <= 1'b1;
    end else begin
      r_wr_valid <= w_spi_commit;
      if (w_spi_commit) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_rx_byte;
      end
      r_n_int <= ~|(r_regs[STATUS_REG] & r_regs[IRQ_EN_REG]);
    end
  end

  assign miso_out     = r_miso;
  assign n_int_out    = r_n_int;
  assign wr_valid_out = r_wr_valid;
  assign wr_addr_out  = r_wr_addr;
  assign wr_data_out  = r_wr_data;

endmodule

// File: tb/tb_max3421e_spi_responder.sv
// ----------------------------------------------------------------------------
// Testbench for max3421e_spi_responder. A bit-banged SPI master drives the
// DUT; a plain register-array model tracks what every register should hold
// and what MISO, the commit port and the interrupt should show.
// ----------------------------------------------------------------------------
module tb_max3421e_spi_responder;

  localparam int HALF = 5;   // SCLK half period in clk_in cycles (SCLK = clk/10)

`ifdef MAX3421E_W1C_IRQ_EN
  localparam bit W1C = 1'b1;
`else
  localparam bit W1C = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       n_rst_in;
  logic       sclk_in;
  logic       mosi_in;
  logic       n_ss_in;
  logic       miso_out;
  logic       n_int_out;
  logic       host_wr_in;
  logic [4:0] host_addr_in;
  logic [7:0] host_data_in;
  logic       wr_valid_out;
  logic [4:0] wr_addr_out;
  logic [7:0] wr_data_out;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_regs [32];
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];

  int         wv_cnt = 0;
  logic [4:0] wv_addr = 5'd0;
  logic [7:0] wv_data = 8'h00;

  max3421e_spi_responder dut (
    .clk_in       (clk_in),
    .n_rst_in     (n_rst_in),
    .sclk_in      (sclk_in),
    .mosi_in      (mosi_in),
    .n_ss_in      (n_ss_in),
    .miso_out     (miso_out),
    .n_int_out    (n_int_out),
    .host_wr_in   (host_wr_in),
    .host_addr_in (host_addr_in),
    .host_data_in (host_data_in),
    .wr_valid_out (wr_valid_out),
    .wr_addr_out  (wr_addr_out),
    .wr_data_out  (wr_data_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (n_rst_in && wr_valid_out) begin
      wv_cnt  = wv_cnt + 1;
      wv_addr = wr_addr_out;
      wv_data = wr_data_out;
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Master transfer of nbytes from tx_buf; MISO captured just before each
  // rise. abort_bits >= 0 deselects after that many bits have been clocked.
  task automatic spi_xfer(input int nbytes, input int abort_bits);
    int bits;
    bit stop;
    bits = 0;
    stop = 1'b0;
    n_ss_in = 1'b0;
    repeat (2*HALF) @(negedge clk_in);
    for (int b = 0; b < nbytes && !stop; b++) begin
      for (int k = 7; k >= 0 && !stop; k--) begin
        if (bits == abort_bits) begin
          stop = 1'b1;
        end else begin
          mosi_in = tx_buf[b][k];
          repeat (HALF) @(negedge clk_in);
          rx_buf[b][k] = miso_out;
          sclk_in = 1'b1;
          repeat (HALF) @(negedge clk_in);
          sclk_in = 1'b0;
          bits++;
        end
      end
    end
    repeat (HALF) @(negedge clk_in);
    n_ss_in = 1'b1;
    mosi_in = 1'b0;
    repeat (3*HALF) @(negedge clk_in);
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    host_addr_in = a;
    host_data_in = d;
    host_wr_in   = 1'b1;
    @(negedge clk_in);
    host_wr_in   = 1'b0;
    m_regs[a]    = d;
  endtask

  function automatic logic [7:0] cmd_byte(input logic [4:0] a, input logic wr);
    logic [31:0] r;
    r = $urandom;
    return {a, r[0], wr, r[1]};
  endfunction

  task automatic spi_write(input logic [4:0] a, input logic [7:0] d);
    int         c0;
    logic [7:0] st;
    c0 = wv_cnt;
    st = m_regs[25];
    tx_buf[0] = cmd_byte(a, 1'b1);
    tx_buf[1] = d;
    spi_xfer(2, -1);
    chk_val("wr_status_byte", rx_buf[0], st);
    chk_val("wr_miso_zero", rx_buf[1], 8'h00);
    chk_val("wr_pulse_count", wv_cnt - c0, 1);
    chk_val("wr_addr", wv_addr, a);
    chk_val("wr_data", wv_data, d);
    if (W1C && a == 5'd25) m_regs[25] = m_regs[25] & ~d;
    else                   m_regs[a]  = d;
  endtask

  task automatic spi_read(input logic [4:0] a, input int nb);
    int c0;
    c0 = wv_cnt;
    tx_buf[0] = cmd_byte(a, 1'b0);
    for (int i = 1; i <= nb; i++) tx_buf[i] = 8'($urandom);
    spi_xfer(nb + 1, -1);
    chk_val("rd_status_byte", rx_buf[0], m_regs[25]);
    for (int i = 1; i <= nb; i++) begin
      chk_val($sformatf("rd_reg%0d_byte%0d", a, i), rx_buf[i], m_regs[a]);
    end
    chk_val("rd_no_pulse", wv_cnt - c0, 0);
  endtask

  task automatic chk_irq();
    repeat (3) @(negedge clk_in);
    chk_val("n_int", n_int_out, ((m_regs[25] & m_regs[26]) == 8'h00));
  endtask

  initial begin
    int c0;
    n_rst_in     = 1'b0;
    sclk_in      = 1'b0;
    mosi_in      = 1'b0;
    n_ss_in      = 1'b1;
    host_wr_in   = 1'b0;
    host_addr_in = 5'd0;
    host_data_in = 8'h00;
    for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;

    // Reset held while the bus wiggles
    for (int i = 0; i < 6; i++) begin
      sclk_in = ~sclk_in;
      n_ss_in = i[1];
      mosi_in = 1'b1;
      repeat (2) @(negedge clk_in);
      chk_val("rst_miso", miso_out, 1'b0);
      chk_val("rst_n_int", n_int_out, 1'b1);
      chk_val("rst_wr_valid", wr_valid_out, 1'b0);
    end
    chk_val("rst_wr_addr", wr_addr_out, 5'd0);
    chk_val("rst_wr_data", wr_data_out, 8'h00);
    sclk_in = 1'b0;
    n_ss_in = 1'b1;
    mosi_in = 1'b0;
    repeat (3) @(negedge clk_in);
    n_rst_in = 1'b1;
    repeat (4) @(negedge clk_in);

    for (int a = 0; a < 32; a++) spi_read(5'(a), 1);
    chk_irq();

    // Write reg 17 then read it back
    spi_write(5'd17, 8'h5C);
    spi_read(5'd17, 1);

    // Read burst repeats the same register
    host_write(5'd8, 8'h3C);
    spi_read(5'd8, 3);

    // Status byte during command
    host_write(5'd25, 8'hA5);
    spi_read(5'd3, 1);
    chk_val("status_a5", rx_buf[0], 8'hA5);
    host_write(5'd25, 8'h00);

    // Interrupt and aborted write
    host_write(5'd25, 8'h04);
    chk_irq();
    host_write(5'd26, 8'h04);
    chk_irq();
    c0 = wv_cnt;
    tx_buf[0] = 8'hD2;
    tx_buf[1] = 8'h99;
    spi_xfer(2, 12);
    chk_val("abort_no_pulse", wv_cnt - c0, 0);
    spi_read(5'd26, 1);
    chk_irq();

    // STATUS_REG write semantics
    host_write(5'd25, 8'h0F);
    spi_write(5'd25, 8'h05);
    spi_read(5'd25, 1);
    chk_val("status_write_result", rx_buf[1], W1C ? 8'h0A : 8'h05);
    chk_irq();

    // Randomized host/SPI traffic
    for (int it = 0; it < 50; it++) begin
      logic [4:0] a;
      logic [7:0] d;
      a = 5'($urandom_range(0, 31));
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0: host_write(a, d);
        1: spi_write(a, d);
        default: spi_read(a, $urandom_range(1, 3));
      endcase
      chk_irq();
    end

    // Host writes landing mid-transfer on other registers
    for (int it = 0; it < 6; it++) begin
      logic [4:0] sa;
      logic [4:0] ha;
      logic [7:0] sd;
      logic [7:0] hd;
      int         dly;
      sa  = 5'($urandom_range(0, 23));
      ha  = 5'((sa + 5'd1 + 5'($urandom_range(0, 20))) % 24);
      if (ha == sa) ha = 5'(sa ^ 5'd1);
      sd  = 8'($urandom);
      hd  = 8'($urandom);
      dly = $urandom_range(0, 170);
      fork
        spi_write(sa, sd);
        begin
          repeat (dly) @(negedge clk_in);
          host_write(ha, hd);
        end
      join
      spi_read(sa, 1);
      spi_read(ha, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
